alu: RTL and testbench

- 32-bit integer ALU for the RV32I pipeline execute stage.
- Computes a result from operands a and b selected by a 4-bit opcode, and flags a zero result (used for branch decisions).
- Combinational result/zero are available in the same cycle.
- A registered copy (one pipeline stage, with valid) feeds the EX/MEM boundary.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_shifter.sv | 29 ++
 rtl/alu.sv | 105 ++++++++++
 tb/tb_alu.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encoding and widths for the RV32I execute ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = $clog2(XLEN);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLT   = 4'b0010,
        ALU_SLLI  = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_LEFT        = 2'd0,
        SH_RIGHT_LOGIC = 2'd1,
        SH_RIGHT_ARITH = 2'd2
    } shift_mode_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// ============================================================================
// Module      : alu_shifter
// Description : Barrel shifter with left, logical-right and arithmetic-right.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shifter
    import alu_pkg::*;
#(
    parameter int DATA_W = XLEN
) (
    input  logic [DATA_W-1:0]          a,
    input  logic [$clog2(DATA_W)-1:0]  shamt,
    input  shift_mode_e                mode,
    output logic [DATA_W-1:0]          y
);

    always_comb begin
        y = a;
        case (mode)
            SH_LEFT:        y = a << shamt;
            SH_RIGHT_LOGIC: y = a >> shamt;
            SH_RIGHT_ARITH: y = $unsigned($signed(a) >>> shamt);
            default:        y = a;
        endcase
    end

endmodule : alu_shifter
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : RV32I execute-stage ALU with combinational result/zero and a
//               valid-qualified EX/MEM register stage.
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_op,
    input  logic            in_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [XLEN-1:0] result_q,
    output logic            zero_q,
    output logic            out_valid
);

    localparam logic [XLEN-1:0] c_zero = '0;

    alu_op_e          w_op;
    logic [XLEN-1:0]  w_sum;
    logic [XLEN-1:0]  w_diff;
    logic             w_lt_signed;
    logic             w_lt_unsigned;
    shift_mode_e      w_shift_mode;
    logic [XLEN-1:0]  w_shift_out;
    logic [XLEN-1:0]  w_result;

    logic [XLEN-1:0]  r_result;
    logic             r_zero;
    logic             r_valid;

    assign w_op          = alu_op_e'(alu_op);
    assign w_sum         = a + b;
    assign w_diff        = a - b;
    assign w_lt_signed   = $signed(a) < $signed(b);
    assign w_lt_unsigned = a < b;

    always_comb begin
        w_shift_mode = SH_LEFT;
        if (w_op == ALU_SRL) begin
            w_shift_mode = SH_RIGHT_LOGIC;
        end else if (w_op == ALU_SRA) begin
            w_shift_mode = SH_RIGHT_ARITH;
        end
    end

    alu_shifter #(
        .DATA_W (XLEN)
    ) u_shifter (
        .a     (a),
        .shamt (b[SHAMT_W-1:0]),
        .mode  (w_shift_mode),
        .y     (w_shift_out)
    );

    // Reserved opcodes fall to the default and produce zero.
    always_comb begin
        w_result = c_zero;
        case (w_op)
            ALU_ADD:   w_result = w_sum;
            ALU_SUB:   w_result = w_diff;
            ALU_SLT:   w_result = {{(XLEN-1){1'b0}}, w_lt_signed};
            ALU_SLLI:  w_result = w_shift_out;
            ALU_SLTU:  w_result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
            ALU_XOR:   w_result = a ^ b;
            ALU_SRL:   w_result = w_shift_out;
            ALU_SRA:   w_result = w_shift_out;
            ALU_OR:    w_result = a | b;
            ALU_AND:   w_result = a & b;
            ALU_PASSB: w_result = b;
            default:   w_result = c_zero;
        endcase
    end

    assign result = w_result;
    assign zero   = (w_result == c_zero);

    // Payload holds when in_valid is low so downstream sees the last valid op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= c_zero;
            r_zero   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_result;
                r_zero   <= (w_result == c_zero);
            end
        end
    end

    assign result_q  = r_result;
    assign zero_q    = r_zero;
    assign out_valid = r_valid;

endmodule : alu
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu
// Description : Self-checking bench for alu: directed vectors plus random ops
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu;
    import alu_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      alu_op;
    logic            in_valid;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    logic [XLEN-1:0] exp_rq;
    logic            exp_zq;
    logic            exp_v;

    always #5 clk = ~clk;

    alu dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .in_valid  (in_valid),
        .result    (result),
        .zero      (zero),
        .result_q  (result_q),
        .zero_q    (zero_q),
        .out_valid (out_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference model: plain integer arithmetic on 64-bit values.
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] x, input logic [31:0] y);
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint m  = 64'h1_0000_0000;
        longint p  = 1;
        longint r  = 0;
        int     sh = int'(uy % 32);
        repeat (sh) p = p * 2;
        case (op)
            0:  r = (ux + uy) % m;
            1:  r = (ux - uy + m) % m;
            2:  r = (sx < sy) ? 1 : 0;
            3:  r = (ux * p) % m;
            4:  r = (ux < uy) ? 1 : 0;
            5:  r = longint'(x ^ y);
            6:  r = ux / p;
            7:  r = ((sx >= 0) ? (sx / p) : -((-sx + p - 1) / p)) & (m - 1);
            8:  r = longint'(x | y);
            9:  r = longint'(x & y);
            10: r = uy;
            default: r = 0;
        endcase
        return 32'(r);
    endfunction

    task automatic comb_vec(input string tag, input logic [3:0] op, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] exp);
        @(negedge clk);
        alu_op = op; a = x; b = y; in_valid = 1'b0;
        #1;
        chk({tag, ".result"}, result, exp);
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; alu_op = 4'd0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.result_q", result_q, 32'd0);
        chk("reset.zero_q", {31'd0, zero_q}, 32'd0);
        chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        comb_vec("add",    4'b0000, 32'd10, 32'd5, 32'd15);
        comb_vec("sub",    4'b0001, 32'd10, 32'd5, 32'd5);
        comb_vec("subneg", 4'b0001, 32'd5, 32'd10, 32'hFFFF_FFFB);
        comb_vec("subeq",  4'b0001, 32'd10, 32'd10, 32'd0);
        comb_vec("slt1",   4'b0010, 32'hFFFF_FFFF, 32'd5, 32'd1);
        comb_vec("slt0",   4'b0010, 32'd10, 32'd5, 32'd0);
        comb_vec("sltu",   4'b0100, 32'hFFFF_FFFF, 32'd5, 32'd0);
        comb_vec("sll",    4'b0011, 32'd5, 32'd2, 32'd20);
        comb_vec("sllmsk", 4'b0011, 32'd1, 32'h21, 32'd2);
        comb_vec("sll0",   4'b0011, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
        comb_vec("srl",    4'b0110, 32'h8000_0000, 32'd31, 32'd1);
        comb_vec("sra",    4'b0111, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
        comb_vec("sra0",   4'b0111, 32'h8000_0001, 32'd0, 32'h8000_0001);
        comb_vec("xor",    4'b0101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
        comb_vec("or",     4'b1000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
        comb_vec("and",    4'b1001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        comb_vec("passb",  4'b1010, 32'hAAAA_AAAA, 32'h1234_5000, 32'h1234_5000);
        comb_vec("rsv15",  4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        comb_vec("rsv11",  4'b1011, 32'd7, 32'd9, 32'd0);

        // Registered stage: capture, hold, then mid-stream reset.
        @(negedge clk);
        alu_op = 4'b0000; a = 32'd10; b = 32'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("reg.capture.result_q", result_q, 32'd15);
        chk("reg.capture.zero_q", {31'd0, zero_q}, 32'd0);
        chk("reg.capture.out_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        alu_op = 4'b0001; a = 32'd10; b = 32'd10; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("reg.hold.result_q", result_q, 32'd15);
        chk("reg.hold.zero_q", {31'd0, zero_q}, 32'd0);
        chk("reg.hold.out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        alu_op = 4'b0000; a = 32'd10; b = 32'd5; in_valid = 1'b1; rst = 1'b1;
        #1;
        chk("rst.comb.result", result, 32'd15);
        @(posedge clk); #1;
        chk("rst.mid.result_q", result_q, 32'd0);
        chk("rst.mid.zero_q", {31'd0, zero_q}, 32'd0);
        chk("rst.mid.out_valid", {31'd0, out_valid}, 32'd0);

        exp_rq = '0; exp_zq = 1'b0; exp_v = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] e;
            @(negedge clk);
            alu_op   = 4'($urandom_range(0, 15));
            a        = $urandom;
            b        = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if (i % 7 == 0) b = a;
            in_valid = 1'($urandom);
            rst      = ($urandom_range(0, 15) == 0);
            #1;
            e = ref_alu(int'(alu_op), a, b);
            chk("rand.result", result, e);
            chk("rand.zero", {31'd0, zero}, {31'd0, e == 32'd0});
            if (rst) begin
                exp_rq = '0; exp_zq = 1'b0; exp_v = 1'b0;
            end else begin
                exp_v = in_valid;
                if (in_valid) begin
                    exp_rq = e; exp_zq = (e == 32'd0);
                end
            end
            @(posedge clk); #1;
            chk("rand.result_q", result_q, exp_rq);
            chk("rand.zero_q", {31'd0, zero_q}, {31'd0, exp_zq});
            chk("rand.out_valid", {31'd0, out_valid}, {31'd0, exp_v});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu
`default_nettype wire
